// File: rtl/div_32_seq.sv
// Iterative signed divider: radix-2 restoring, one quotient bit per cycle, fixed 34-cycle cadence.
// Result is packed {remainder, quotient} to match how the multiplier product is consumed.
module div_32_seq #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_dz,
    output logic [2*N-1:0] o_z
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [N:0]       r_rem;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_divs;
    logic [N-1:0]     r_a;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_bz;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [2*N-1:0]   r_z;

    logic             w_accept;
    logic [N-1:0]     w_a_mag;
    logic [N-1:0]     w_b_mag;
    logic [N:0]       w_rem_sh;
    logic [N:0]       w_diff;
    logic [N-1:0]     w_q_fix;
    logic [N-1:0]     w_r_fix;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
    assign w_a_mag  = i_a[N-1] ? (~i_a + 1'b1) : i_a;
    assign w_b_mag  = i_b[N-1] ? (~i_b + 1'b1) : i_b;
    assign w_rem_sh = {r_rem[N-1:0], r_quo[N-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divs};
    assign w_q_fix  = r_sign_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix  = r_sign_r ? (~r_rem[N-1:0] + 1'b1) : r_rem[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_quo    <= '0;
            r_divs   <= '0;
            r_a      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_bz     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_z      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_sign_q <= i_a[N-1] ^ i_b[N-1];
                        r_sign_r <= i_a[N-1];
                        r_a      <= i_a;
                        r_bz     <= (i_b == '0);
                        r_quo    <= w_a_mag;
                        r_divs   <= w_b_mag;
                        r_rem    <= '0;
                        r_cnt    <= CW'(N - 1);
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    // Dividend bits shift out of the quotient register as quotient bits shift in.
                    if (!w_diff[N]) begin
                        r_rem <= w_diff;
                        r_quo <= {r_quo[N-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh;
                        r_quo <= {r_quo[N-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_bz) begin
                        r_z  <= {r_a, {N{1'b1}}};
                        r_dz <= 1'b1;
                    end else begin
                        r_z  <= {w_r_fix, w_q_fix};
                        r_dz <= 1'b0;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_dz   = r_dz;
    assign o_z    = r_z;

endmodule

// File: doc/div_32_seq.md
# div_32_seq

Iterative signed 32-bit divider that computes quotient and remainder of two's-complement operands over a fixed number of cycles. It is the inverse companion to the combinational 32x32 signed multiplier. It delivers a 64-bit result packed the same way the multiplier's product is consumed by the execute stage: high word is remainder, low word is quotient. It sits beside the multiplier in the execute unit and is controlled by a start/busy/done handshake so the pipeline can stall on it.

## Interface
- N, 32, operand width; result width is 2N (only N=32 is required to be verified)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  request; sampled on rising clk when block is IDLE or DONE
- a  input  N  signed dividend, captured on accepted start
- b  input  N  signed divisor, captured on accepted start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse, result valid
- dz  output  1  divide-by-zero flag for the last result, held with z
- z  output  2N  {remainder[N-1:0], quotient[N-1:0]}, held until next accepted start completes

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1: capture the operands.
  - Record sign_q = a[N-1]^b[N-1] and sign_r = a[N-1].
  - Load |a| and |b| as N-bit unsigned magnitudes. |-2^31| is 32'h80000000 unsigned.
  - Clear the partial remainder and set the iteration counter to N-1.
  - Go to CALC.
- DONE + start=0: go to IDLE.
- CALC: one radix-2 restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract |b| from the (N+1)-bit partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1. Otherwise restore and set it to 0.
  - Counter decrements. After the step at count 0, go to FIX.
- FIX: apply signs and special cases, register z and dz, then go to DONE.
  - Quotient is negated if sign_q. It truncates toward zero.
  - Remainder is negated if sign_r. It takes the sign of the dividend and satisfies a = q*b + r.
  - b==0: z = {a_captured, 32'hFFFFFFFF}, dz=1.
  - a==32'h80000000 and b==32'hFFFFFFFF: z = {32'h0, 32'h80000000}, dz=0. No trap.
- start while in CALC or FIX is ignored. Operand changes after capture are ignored.
- Latency is the same for every operand value, including special cases.

## Timing
- Reset (asynchronous on rst_n low): state=IDLE, busy=0, done=0, dz=0, z=64'h0.
- Edge E0 samples start=1: busy=1 from E0.
- Edges E1..E32 each perform one CALC step.
- Edge E33 performs FIX and registers z and dz:
  - busy=0 and done=1 from E33.
  - done drops at E34 unless it is re-asserted by a new result.
- Result latency: done is visible 33 cycles after the start-sampling edge.
- Throughput: a start held high in the DONE cycle is accepted at E33+1, giving one result per 34 cycles back-to-back.
- z and dz change only at the FIX edge. They are stable from then until the next FIX edge.
- busy and done are never high simultaneously.
- Reset asserted mid-CALC aborts immediately. Outputs take their reset values, and no done pulse follows.

## Test plan
- a=100, b=7, start 1 cycle:
  - done exactly 33 cycles later, z={32'd2, 32'd14}, dz=0.
  - busy high for 33 cycles.
- a=-100 (32'hFFFFFF9C), b=7: z={32'hFFFFFFFE, 32'hFFFFFFF2}.
- a=100, b=-7: z={32'd2, 32'hFFFFFFF2}.
- a=7, b=0: z={32'd7, 32'hFFFFFFFF}, dz=1, same 33-cycle latency.
- a=32'h80000000, b=32'hFFFFFFFF: z={32'h0, 32'h80000000}, dz=0.
- Handshake and reset:
  - Pulse start again at cycle 10 of a busy op with different a/b: the first result is unaffected and no extra done appears.
  - Assert start in the DONE cycle: the second result's done arrives 34 cycles after the first.
  - Drop rst_n at cycle 15 of an op: busy=0, done=0, z=0 immediately, and no done follows.
- Random signed pairs (10k, b≠0) versus a reference model: check a == q*b + r and |r| < |b|.
